// File: rtl/decode_writeback_if.sv
// Decode/write-back bundle: Fetch/Execute/Memory inputs, decoded indices,
// register reads and the debug read port.
interface decode_writeback_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  wb_en;
    logic [3:0]            Ins_Code;
    logic [3:0]            rA;
    logic [3:0]            rB;
    logic                  Cnd;
    logic [DATA_WIDTH-1:0] Val_E;
    logic [DATA_WIDTH-1:0] Val_M;
    logic [3:0]            srcA;
    logic [3:0]            srcB;
    logic [3:0]            dstE;
    logic [3:0]            dstM;
    logic [DATA_WIDTH-1:0] Val_A;
    logic [DATA_WIDTH-1:0] Val_B;
    logic [3:0]            dbg_sel;
    logic [DATA_WIDTH-1:0] dbg_data;

    modport master (
        output wb_en, Ins_Code, rA, rB, Cnd, Val_E, Val_M, dbg_sel,
        input  srcA, srcB, dstE, dstM, Val_A, Val_B, dbg_data
    );

    modport slave (
        input  wb_en, Ins_Code, rA, rB, Cnd, Val_E, Val_M, dbg_sel,
        output srcA, srcB, dstE, dstM, Val_A, Val_B, dbg_data
    );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode and write-back: register-index decode, combinational
// register reads and dstE/dstM commit at the clock edge.
module decode_writeback #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_REGS   = 15,
    parameter int unsigned RSP_ID     = 4
) (
    input logic               clk,
    input logic               rst_n,
    decode_writeback_if.slave bus
);
    localparam logic [3:0] RNone  = 4'hF;
    localparam logic [3:0] RspIdx = 4'(RSP_ID);

    localparam logic [3:0] ICmov  = 4'h2;
    localparam logic [3:0] IIrmov = 4'h3;
    localparam logic [3:0] IRmmov = 4'h4;
    localparam logic [3:0] IMrmov = 4'h5;
    localparam logic [3:0] IOp    = 4'h6;
    localparam logic [3:0] ICall  = 4'h8;
    localparam logic [3:0] IRet   = 4'h9;
    localparam logic [3:0] IPush  = 4'hA;
    localparam logic [3:0] IPop   = 4'hB;

    logic [3:0] src_a, src_b, dst_e, dst_m;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_tab [16];

    // halt, nop, jXX and invalid codes fall through with every index at RNONE
    always_comb begin
        src_a = RNone;
        src_b = RNone;
        dst_e = RNone;
        dst_m = RNone;
        case (bus.Ins_Code)
            ICmov: begin
                src_a = bus.rA;
                dst_e = bus.Cnd ? bus.rB : RNone;
            end
            IIrmov: dst_e = bus.rB;
            IRmmov: begin
                src_a = bus.rA;
                src_b = bus.rB;
            end
            IMrmov: begin
                src_b = bus.rB;
                dst_m = bus.rA;
            end
            IOp: begin
                src_a = bus.rA;
                src_b = bus.rB;
                dst_e = bus.rB;
            end
            ICall: begin
                src_b = RspIdx;
                dst_e = RspIdx;
            end
            IRet: begin
                src_a = RspIdx;
                src_b = RspIdx;
                dst_e = RspIdx;
            end
            IPush: begin
                src_a = bus.rA;
                src_b = RspIdx;
                dst_e = RspIdx;
            end
            IPop: begin
                src_a = RspIdx;
                src_b = RspIdx;
                dst_e = RspIdx;
                dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    // M write is applied after E so popq %rsp leaves Val_M in %rsp
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (bus.wb_en) begin
                if (dst_e == 4'(i)) regs_d[i] = bus.Val_E;
                if (dst_m == 4'(i)) regs_d[i] = bus.Val_M;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Indices without storage (RNONE) read as zero
    for (genvar g = 0; g < 16; g++) begin : g_rd_tab
        if (g < NUM_REGS) begin : g_reg
            assign rd_tab[g] = regs_q[g];
        end else begin : g_none
            assign rd_tab[g] = '0;
        end
    end

    assign bus.srcA     = src_a;
    assign bus.srcB     = src_b;
    assign bus.dstE     = dst_e;
    assign bus.dstM     = dst_m;
    assign bus.Val_A    = rd_tab[src_a];
    assign bus.Val_B    = rd_tab[src_b];
    assign bus.dbg_data = rd_tab[bus.dbg_sel];
endmodule

// File: tb/tb_decode_writeback.sv
// Directed vector bench for decode_writeback: decode, reads, commits and
// asynchronous reset behaviour.
module tb_decode_writeback;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    decode_writeback_if #(.DATA_WIDTH(64)) bus ();

    decode_writeback #(
        .DATA_WIDTH(64),
        .NUM_REGS  (15),
        .RSP_ID    (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    typedef struct {
        logic        wb;
        logic [3:0]  ins;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [3:0]  de;
        logic [3:0]  dm;
        logic [63:0] va;
        logic [63:0] vb;
        logic [3:0]  ck_reg;
        logic [63:0] ck_val;
    } vec_t;

    localparam int NVec = 20;
    vec_t vecs [NVec];

    function automatic vec_t mk(input logic wb, input logic [3:0] ins, input logic [3:0] ra,
                                input logic [3:0] rb, input logic cnd, input logic [63:0] ve,
                                input logic [63:0] vm, input logic [3:0] sa,
                                input logic [3:0] sb, input logic [3:0] de,
                                input logic [3:0] dm, input logic [63:0] va,
                                input logic [63:0] vb, input logic [3:0] ck_reg,
                                input logic [63:0] ck_val);
        vec_t v;
        v.wb = wb; v.ins = ins; v.ra = ra; v.rb = rb; v.cnd = cnd; v.ve = ve; v.vm = vm;
        v.sa = sa; v.sb = sb; v.de = de; v.dm = dm; v.va = va; v.vb = vb;
        v.ck_reg = ck_reg; v.ck_val = ck_val;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic [3:0] ins, input logic [3:0] ra,
                         input logic [3:0] rb, input logic cnd, input logic [63:0] ve,
                         input logic [63:0] vm);
        bus.wb_en    = wb;
        bus.Ins_Code = ins;
        bus.rA       = ra;
        bus.rB       = rb;
        bus.Cnd      = cnd;
        bus.Val_E    = ve;
        bus.Val_M    = vm;
    endtask

    task automatic chk_all_zero(input string name);
        for (int r = 0; r < 15; r++) begin
            bus.dbg_sel = 4'(r);
            #1;
            chk($sformatf("%s_r%0d", name, r), bus.dbg_data, 64'h0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
        bus.dbg_sel = 4'h0;

        // Reset asserted between edges; registers read zero without a clock edge
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_all_zero("por");
        #3 rst_n = 1'b1;

        //                 wb    ins   ra    rb    cnd   Val_E        Val_M
        //                 srcA  srcB  dstE  dstM  Val_A        Val_B        chk reg/value
        vecs[0]  = mk(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0,
                      4'hF, 4'hF, 4'h2, 4'hF, 64'h0, 64'h0, 4'h2, 64'h1234);
        vecs[1]  = mk(1'b1, 4'h2, 4'h2, 4'h3, 1'b0, 64'h77, 64'h0,
                      4'h2, 4'hF, 4'hF, 4'hF, 64'h1234, 64'h0, 4'h3, 64'h0);
        vecs[2]  = mk(1'b1, 4'h2, 4'h2, 4'h3, 1'b1, 64'h77, 64'h0,
                      4'h2, 4'hF, 4'h3, 4'hF, 64'h1234, 64'h0, 4'h3, 64'h77);
        vecs[3]  = mk(1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'h200, 64'h0,
                      4'hF, 4'hF, 4'h4, 4'hF, 64'h0, 64'h0, 4'h4, 64'h200);
        vecs[4]  = mk(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0,
                      4'hF, 4'hF, 4'h5, 4'hF, 64'h0, 64'h0, 4'h5, 64'h55);
        vecs[5]  = mk(1'b0, 4'hA, 4'h5, 4'hF, 1'b0, 64'h1F8, 64'h0,
                      4'h5, 4'h4, 4'h4, 4'hF, 64'h55, 64'h200, 4'h4, 64'h200);
        vecs[6]  = mk(1'b1, 4'hA, 4'h5, 4'hF, 1'b0, 64'h1F8, 64'h0,
                      4'h5, 4'h4, 4'h4, 4'hF, 64'h55, 64'h200, 4'h4, 64'h1F8);
        vecs[7]  = mk(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hBEEF,
                      4'h4, 4'h4, 4'h4, 4'h4, 64'h1F8, 64'h1F8, 4'h4, 64'hBEEF);
        vecs[8]  = mk(1'b1, 4'hD, 4'h2, 4'h3, 1'b1, 64'hFFFF, 64'hEEEE,
                      4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 4'h2, 64'h1234);
        vecs[9]  = mk(1'b1, 4'h6, 4'h2, 4'h3, 1'b0, 64'h9999, 64'h0,
                      4'h2, 4'h3, 4'h3, 4'hF, 64'h1234, 64'h77, 4'h3, 64'h9999);
        vecs[10] = mk(1'b1, 4'h5, 4'h6, 4'h2, 1'b0, 64'h1240, 64'hCAFE,
                      4'hF, 4'h2, 4'hF, 4'h6, 64'h0, 64'h1234, 4'h6, 64'hCAFE);
        vecs[11] = mk(1'b1, 4'h4, 4'h6, 4'h2, 1'b0, 64'h1, 64'h2,
                      4'h6, 4'h2, 4'hF, 4'hF, 64'hCAFE, 64'h1234, 4'h2, 64'h1234);
        vecs[12] = mk(1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'hBEE7, 64'h0,
                      4'hF, 4'h4, 4'h4, 4'hF, 64'h0, 64'hBEEF, 4'h4, 64'hBEE7);
        vecs[13] = mk(1'b1, 4'h9, 4'hF, 4'hF, 1'b0, 64'hBEEF, 64'h400,
                      4'h4, 4'h4, 4'h4, 4'hF, 64'hBEE7, 64'hBEE7, 4'h4, 64'hBEEF);
        vecs[14] = mk(1'b0, 4'h0, 4'h2, 4'h3, 1'b0, 64'h5, 64'h6,
                      4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 4'h3, 64'h9999);
        vecs[15] = mk(1'b1, 4'h7, 4'hF, 4'hF, 1'b1, 64'h5, 64'h6,
                      4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 4'h6, 64'hCAFE);
        vecs[16] = mk(1'b1, 4'hB, 4'h7, 4'hF, 1'b0, 64'hBEF7, 64'hD00D,
                      4'h4, 4'h4, 4'h4, 4'h7, 64'hBEEF, 64'hBEEF, 4'h7, 64'hD00D);
        vecs[17] = mk(1'b1, 4'h6, 4'h7, 4'hE, 1'b0, 64'hE0E, 64'h0,
                      4'h7, 4'hE, 4'hE, 4'hF, 64'hD00D, 64'h0, 4'hE, 64'hE0E);
        vecs[18] = mk(1'b1, 4'h4, 4'hE, 4'hE, 1'b0, 64'h3, 64'h4,
                      4'hE, 4'hE, 4'hF, 4'hF, 64'hE0E, 64'hE0E, 4'hE, 64'hE0E);
        vecs[19] = mk(1'b1, 4'h6, 4'hF, 4'hF, 1'b0, 64'h1, 64'h2,
                      4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0, 4'h4, 64'hBEF7);

        for (int i = 0; i < NVec; i++) begin
            @(negedge clk);
            drive(vecs[i].wb, vecs[i].ins, vecs[i].ra, vecs[i].rb, vecs[i].cnd,
                  vecs[i].ve, vecs[i].vm);
            #1;
            chk($sformatf("v%0d_srcA", i), 64'(bus.srcA), 64'(vecs[i].sa));
            chk($sformatf("v%0d_srcB", i), 64'(bus.srcB), 64'(vecs[i].sb));
            chk($sformatf("v%0d_dstE", i), 64'(bus.dstE), 64'(vecs[i].de));
            chk($sformatf("v%0d_dstM", i), 64'(bus.dstM), 64'(vecs[i].dm));
            chk($sformatf("v%0d_Val_A", i), bus.Val_A, vecs[i].va);
            chk($sformatf("v%0d_Val_B", i), bus.Val_B, vecs[i].vb);
            @(posedge clk);
            #1;
            bus.wb_en   = 1'b0;
            bus.dbg_sel = vecs[i].ck_reg;
            #1;
            chk($sformatf("v%0d_R%0h", i, vecs[i].ck_reg), bus.dbg_data, vecs[i].ck_val);
        end

        // Reset mid-cycle with a write pending: everything clears, write is lost
        @(negedge clk);
        drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'hBBBB, 64'h0);
        #2 rst_n = 1'b0;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        bus.dbg_sel = 4'h2;
        #1;
        chk("rst_hold_R2", bus.dbg_data, 64'h0);
        chk("rst_hold_ValB", bus.Val_B, 64'h0);
        @(negedge clk);
        bus.wb_en = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("post_rst_R2", bus.dbg_data, 64'h0);

        // Write path recovers after reset release
        @(negedge clk);
        drive(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h5A5A, 64'h0);
        @(posedge clk);
        #1;
        bus.wb_en   = 1'b0;
        bus.dbg_sel = 4'h1;
        #1;
        chk("recover_R1", bus.dbg_data, 64'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 SEQ decode and write-back stage, sitting directly downstream of Fetch.
- Consumes Ins_Code, rA, rB from Fetch, and Val_E, Val_M, Cnd from Execute and Memory.
- Holds the 15-entry architectural register file.
- Reads Val_A and Val_B combinationally during decode; commits dstE and dstM writes on the rising clock edge at the end of the instruction's cycle.

Parameters:
- DATA_WIDTH, 64, register and data width.
- NUM_REGS, 15, architectural registers; index 4'hF is RNONE.
- RSP_ID, 4, register index of %rsp.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- wb_en  input  1  write-back enable; 0 suppresses all writes (halt or error status)
- Ins_Code  input  4  instruction code from Fetch
- rA  input  4  register A field from Fetch
- rB  input  4  register B field from Fetch
- Cnd  input  1  condition result from Execute; used only by cmovXX
- Val_E  input  DATA_WIDTH  ALU result to write to dstE
- Val_M  input  DATA_WIDTH  memory read data to write to dstM
- srcA  output  4  decoded source A index
- srcB  output  4  decoded source B index
- dstE  output  4  decoded E destination index
- dstM  output  4  decoded M destination index
- Val_A  output  DATA_WIDTH  register file read of srcA
- Val_B  output  DATA_WIDTH  register file read of srcB
- dbg_sel  input  4  debug read index
- dbg_data  output  DATA_WIDTH  register file read of dbg_sel

Behaviour:
- Reset (rst_n=0): asynchronously clears all 15 registers to 0 immediately, independent of clk.
  - While rst_n is held low, no writes occur and reads return 0.
  - Reset asserted mid-cycle discards that cycle's pending write.
- Opcodes: halt 0, nop 1, cmovXX 2, irmovq 3, rmmovq 4, mrmovq 5, OPq 6, jXX 7, call 8, ret 9, pushq A, popq B.
- srcA:
  - rA for 2, 4, 6, A.
  - RSP_ID for 9, B.
  - else F.
- srcB:
  - rB for 4, 5, 6.
  - RSP_ID for 8, 9, A, B.
  - else F.
- dstE:
  - 2: rB if Cnd=1, else F.
  - rB for 3, 6.
  - RSP_ID for 8, 9, A, B.
  - else F.
- dstM: rA for 5, B; else F.
- Invalid Ins_Code (C–F): all four indices are F.
- Reads:
  - Purely combinational, zero latency.
  - Index F returns 0.
  - Reads return the pre-edge value; a write in cycle N is visible from cycle N+1. No internal forwarding.
- Writes at posedge clk when rst_n=1 and wb_en=1:
  - R[dstE] <= Val_E if dstE != F.
  - R[dstM] <= Val_M if dstM != F.
- dstE == dstM, both != F (popq %rsp): the M write wins; R[4] takes Val_M.
- Writes to index F are ignored; no storage exists for F.
- wb_en=0: register file holds; decode outputs remain valid.
- All arithmetic lives elsewhere; this block does no width conversion and stores full DATA_WIDTH values.
- Expected implementation: about 150–250 lines of RTL, including the register array, decode logic, write port and debug mux.

Test Plan:
- Reset: pulse rst_n low between edges.
  - R0–R14 read 0 via dbg_data immediately, without waiting for a clock edge.
- irmovq: Ins_Code=3, rB=2, Val_E=64'h1234, wb_en=1.
  - Same cycle: dstE=2, dstM=F, Val_B reads the old value 0.
  - After the edge: dbg_sel=2 gives 64'h1234.
- cmovXX with Cnd=0: Ins_Code=2, rA=2, rB=3, Cnd=0.
  - dstE=F; R3 unchanged after the edge.
- cmovXX with Cnd=1: same instruction with Cnd=1.
  - dstE=3; R3 equals Val_E after the edge.
- popq %rsp: Ins_Code=B, rA=4, Val_E=64'h100, Val_M=64'hBEEF.
  - srcA=4, srcB=4, dstE=4, dstM=4.
  - R4 = 64'hBEEF after the edge.
- pushq: preload R4=64'h200, R5=64'h55; Ins_Code=A, rA=5.
  - Val_A=64'h55, Val_B=64'h200.
  - With wb_en=0 and Val_E=64'h1F8: R4 stays 64'h200.
  - With wb_en=1: R4 = 64'h1F8 after the edge.
- Invalid Ins_Code=4'hD: all indices are F, Val_A=Val_B=0, and no register changes.
